// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path.
//   UART_BYTE_W : width of one transmitted byte
//   GAP_CYCLES  : minimum cycles uart_en must stay low between launches so the
//                 transmitter's edge detector sees a fresh rising edge
//   arb_state_e : arbiter FSM encoding
//   wrap_inc    : modulo-n increment for index pointers (n need not be 2^k)
package uart_pkg;

    localparam int unsigned UART_BYTE_W = 8;
    localparam int unsigned GAP_CYCLES  = 2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LAUNCH  = 2'd1,
        SENDING = 2'd2
    } arb_state_e;

    function automatic int unsigned wrap_inc(int unsigned v, int unsigned n);
        return (v == n - 1) ? 0 : v + 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker.
//   valid     : request vector
//   ptr       : highest-priority index for this pick
//   winner    : first valid index searching upward from ptr, wrapping N_REQ-1 -> 0
//   any_valid : at least one request is present (winner is 0 otherwise)
module rr_arbiter #(
    parameter int unsigned N_REQ = 4
) (
    input  logic [N_REQ-1:0]         valid,
    input  logic [$clog2(N_REQ)-1:0] ptr,
    output logic [$clog2(N_REQ)-1:0] winner,
    output logic                     any_valid
);

    localparam int unsigned IDX_W = $clog2(N_REQ);

    // One spare bit so ptr + k never overflows before the wrap compare.
    logic [IDX_W:0] idx;

    always_comb begin
        winner    = '0;
        any_valid = 1'b0;
        idx       = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            idx = {1'b0, ptr} + (IDX_W + 1)'(k);
            if (idx >= (IDX_W + 1)'(N_REQ)) begin
                idx = idx - (IDX_W + 1)'(N_REQ);
            end
            if (!any_valid && valid[idx[IDX_W-1:0]]) begin
                any_valid = 1'b1;
                winner    = idx[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one uart_tx between N_REQ byte requesters with round-robin fairness
// and packet locking (req_last ends a packet).
//   sys_clk, sys_rst_n : clock, asynchronous active-low reset
//   req_valid/data/last: per-requester byte handshake inputs (held until ready)
//   req_ready          : one-hot, one-cycle accept pulse
//   uart_en, uart_din  : start level and byte to uart_tx (rising edge starts)
//   uart_tx_busy       : busy flag from uart_tx
//   grant_id           : current owner of the transmitter
//   locked             : packet in progress, only grant_id is eligible
//   err_timeout        : one-cycle pulse when busy never rose after a launch
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int unsigned N_REQ    = 4,
    parameter int unsigned WAIT_MAX = 16
) (
    input  logic                           sys_clk,
    input  logic                           sys_rst_n,
    input  logic [N_REQ-1:0]               req_valid,
    input  logic [N_REQ*UART_BYTE_W-1:0]   req_data,
    input  logic [N_REQ-1:0]               req_last,
    output logic [N_REQ-1:0]               req_ready,
    output logic                           uart_en,
    output logic [UART_BYTE_W-1:0]         uart_din,
    input  logic                           uart_tx_busy,
    output logic [$clog2(N_REQ)-1:0]       grant_id,
    output logic                           locked,
    output logic                           err_timeout
);

    localparam int unsigned IDX_W = $clog2(N_REQ);
    localparam int unsigned GAP_W = $clog2(GAP_CYCLES + 1);

    arb_state_e             state_q, state_d;
    logic [N_REQ-1:0]       ready_q, ready_d;
    logic                   en_q, en_d;
    logic [UART_BYTE_W-1:0] din_q, din_d;
    logic [IDX_W-1:0]       grant_q, grant_d;
    logic                   locked_q, locked_d;
    logic                   err_q, err_d;
    logic [IDX_W-1:0]       ptr_q, ptr_d;
    logic [7:0]             wait_q, wait_d;
    logic [GAP_W-1:0]       gap_q, gap_d;

    logic [IDX_W-1:0] arb_winner;
    logic             arb_any;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_ok;
    logic             gap_ok;
    logic [IDX_W-1:0] ptr_next;

    rr_arbiter #(
        .N_REQ (N_REQ)
    ) u_rr_arbiter (
        .valid     (req_valid),
        .ptr       (ptr_q),
        .winner    (arb_winner),
        .any_valid (arb_any)
    );

    // While locked the owner is the only candidate, valid or not.
    assign pick_idx = locked_q ? grant_q : arb_winner;
    assign pick_ok  = locked_q ? req_valid[grant_q] : arb_any;
    assign gap_ok   = (gap_q >= GAP_W'(GAP_CYCLES));
    assign ptr_next = IDX_W'(wrap_inc(32'(grant_q), N_REQ));

    always_comb begin
        state_d  = state_q;
        ready_d  = '0;
        en_d     = en_q;
        din_d    = din_q;
        grant_d  = grant_q;
        locked_d = locked_q;
        err_d    = 1'b0;
        ptr_d    = ptr_q;
        wait_d   = wait_q;

        unique case (state_q)
            IDLE: begin
                if (!uart_tx_busy && gap_ok && pick_ok) begin
                    ready_d[pick_idx] = 1'b1;
                    din_d    = req_data[32'(pick_idx) * UART_BYTE_W +: UART_BYTE_W];
                    grant_d  = pick_idx;
                    en_d     = 1'b1;
                    locked_d = ~req_last[pick_idx];
                    wait_d   = '0;
                    state_d  = LAUNCH;
                end
            end
            LAUNCH: begin
                if (uart_tx_busy) begin
                    en_d    = 1'b0;
                    wait_d  = '0;
                    state_d = SENDING;
                end else if (wait_q == 8'(WAIT_MAX - 1)) begin
                    // Transmitter never acknowledged: drop the byte and the packet.
                    en_d     = 1'b0;
                    err_d    = 1'b1;
                    locked_d = 1'b0;
                    ptr_d    = ptr_next;
                    wait_d   = '0;
                    state_d  = IDLE;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            SENDING: begin
                en_d = 1'b0;
                if (!uart_tx_busy) begin
                    state_d = IDLE;
                    if (!locked_q) begin
                        ptr_d = ptr_next;
                    end
                end
            end
            default: begin
                en_d    = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // Consecutive cycles uart_en has been low, saturating at GAP_CYCLES.
    assign gap_d = en_d ? '0 : (gap_ok ? gap_q : gap_q + 1'b1);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q  <= IDLE;
            ready_q  <= '0;
            en_q     <= 1'b0;
            din_q    <= '0;
            grant_q  <= '0;
            locked_q <= 1'b0;
            err_q    <= 1'b0;
            ptr_q    <= '0;
            wait_q   <= '0;
            gap_q    <= GAP_W'(GAP_CYCLES);
        end else begin
            state_q  <= state_d;
            ready_q  <= ready_d;
            en_q     <= en_d;
            din_q    <= din_d;
            grant_q  <= grant_d;
            locked_q <= locked_d;
            err_q    <= err_d;
            ptr_q    <= ptr_d;
            wait_q   <= wait_d;
            gap_q    <= gap_d;
        end
    end

    assign req_ready   = ready_q;
    assign uart_en     = en_q;
    assign uart_din    = din_q;
    assign grant_id    = grant_q;
    assign locked      = locked_q;
    assign err_timeout = err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a small behavioural uart_tx model
// (2-flop edge capture, BIT_CYC cycles per bit, 8N1 framing).
module tb_uart_tx_arbiter;

    localparam int unsigned N_REQ    = 4;
    localparam int unsigned WAIT_MAX = 16;
    localparam int          BIT_CYC  = 8;

    logic              sys_clk   = 1'b0;
    logic              sys_rst_n = 1'b0;
    logic [3:0]        req_valid = '0;
    logic [31:0]       req_data  = '0;
    logic [3:0]        req_last  = '0;
    logic [3:0]        req_ready;
    logic              uart_en;
    logic [7:0]        uart_din;
    logic              uart_tx_busy;
    logic [1:0]        grant_id;
    logic              locked;
    logic              err_timeout;

    logic busy_tie   = 1'b0;
    logic force_busy = 1'b0;

    logic [8:0] src_q [4][$];
    logic [7:0] sent_q [$];
    int         ready_log [$];
    int         viol    = 0;
    int         err_cnt = 0;
    logic [3:0] prev_ready = '0;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 sys_clk = ~sys_clk;

    uart_tx_arbiter #(
        .N_REQ    (N_REQ),
        .WAIT_MAX (WAIT_MAX)
    ) dut (
        .sys_clk      (sys_clk),
        .sys_rst_n    (sys_rst_n),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_last     (req_last),
        .req_ready    (req_ready),
        .uart_en      (uart_en),
        .uart_din     (uart_din),
        .uart_tx_busy (uart_tx_busy),
        .grant_id     (grant_id),
        .locked       (locked),
        .err_timeout  (err_timeout)
    );

    // Behavioural transmitter.
    logic       en_s1, en_s2, m_busy, tx_line;
    logic [9:0] m_sh;
    int         m_cyc, m_bit;

    assign uart_tx_busy = busy_tie ? 1'b0 : (force_busy | m_busy);

    always @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            en_s1   <= 1'b0;
            en_s2   <= 1'b0;
            m_busy  <= 1'b0;
            tx_line <= 1'b1;
            m_sh    <= '1;
            m_cyc   <= 0;
            m_bit   <= 0;
        end else begin
            en_s1 <= uart_en;
            en_s2 <= en_s1;
            if (!m_busy) begin
                if (en_s1 && !en_s2) begin
                    m_busy  <= 1'b1;
                    m_sh    <= {1'b1, uart_din, 1'b0};
                    tx_line <= 1'b0;
                    m_cyc   <= 0;
                    m_bit   <= 0;
                    sent_q.push_back(uart_din);
                end
            end else if (m_cyc == BIT_CYC - 1) begin
                m_cyc <= 0;
                if (m_bit == 9) begin
                    m_busy  <= 1'b0;
                    tx_line <= 1'b1;
                end else begin
                    m_bit   <= m_bit + 1;
                    tx_line <= m_sh[m_bit+1];
                end
            end else begin
                m_cyc <= m_cyc + 1;
            end
        end
    end

    // Requesters: present the head of each queue, pop on ready; also log grants.
    always @(negedge sys_clk) begin
        if (sys_rst_n) begin
            if (!$onehot0(req_ready)) viol++;
            if ((req_ready & prev_ready) != 4'b0) viol++;
            if (err_timeout) err_cnt++;
            for (int i = 0; i < 4; i++) begin
                if (req_ready[i]) ready_log.push_back(i);
            end
        end
        prev_ready = req_ready;
        for (int i = 0; i < 4; i++) begin
            if (sys_rst_n && req_ready[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
            if (src_q[i].size() > 0) begin
                req_valid[i]        = 1'b1;
                req_data[8*i +: 8]  = src_q[i][0][7:0];
                req_last[i]         = src_q[i][0][8];
            end else begin
                req_valid[i]        = 1'b0;
                req_data[8*i +: 8]  = 8'h00;
                req_last[i]         = 1'b0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    function automatic int sent_at(int i);
        return (i < sent_q.size()) ? int'(sent_q[i]) : -1;
    endfunction

    function automatic int ready_at(int i);
        return (i < ready_log.size()) ? ready_log[i] : -1;
    endfunction

    task automatic do_reset();
        sys_rst_n  = 1'b0;
        busy_tie   = 1'b0;
        force_busy = 1'b0;
        for (int i = 0; i < 4; i++) src_q[i].delete();
        repeat (3) @(negedge sys_clk);
        sent_q.delete();
        ready_log.delete();
        sys_rst_n = 1'b1;
    endtask

    task automatic wait_sent(input int n, input int budget);
        for (int t = 0; t < budget && sent_q.size() < n; t++) @(negedge sys_clk);
        // Let the last frame finish so the DUT is back in IDLE.
        for (int t = 0; t < budget && uart_tx_busy; t++) @(negedge sys_clk);
        check("sent_count", sent_q.size(), n);
    endtask

    task automatic rx_frame(output logic [9:0] bits, output logic seen);
        seen = 1'b0;
        bits = '0;
        for (int t = 0; t < 200 && tx_line !== 1'b0; t++) @(negedge sys_clk);
        if (tx_line === 1'b0) begin
            seen = 1'b1;
            repeat (3) @(negedge sys_clk);
            bits[0] = tx_line;
            for (int b = 1; b < 10; b++) begin
                repeat (BIT_CYC) @(negedge sys_clk);
                bits[b] = tx_line;
            end
        end
    endtask

    initial begin
        logic [9:0] bits;
        logic       seen;
        int         hi, lo, n, err0;

        // Reset state
        repeat (2) @(negedge sys_clk);
        check("rst_ready", req_ready, 4'b0);
        check("rst_en", uart_en, 1'b0);
        check("rst_din", uart_din, 8'h00);
        check("rst_grant", grant_id, 2'd0);
        check("rst_locked", locked, 1'b0);
        check("rst_err", err_timeout, 1'b0);

        // Single byte from requester 2
        do_reset();
        src_q[2].push_back({1'b1, 8'hA5});
        rx_frame(bits, seen);
        check("single_start_seen", seen, 1'b1);
        check("single_locked", locked, 1'b0);
        check("single_grant", grant_id, 2'd2);
        check("single_line_bits", bits, 10'h34A);
        wait_sent(1, 400);
        check("single_ready_cnt", ready_log.size(), 1);
        check("single_ready_id", ready_at(0), 2);
        check("single_byte", sent_at(0), 8'hA5);

        // Round robin, all four valid
        do_reset();
        for (int i = 0; i < 4; i++) src_q[i].push_back({1'b1, 8'h10 + 8'(i)});
        src_q[0].push_back({1'b1, 8'h10});
        wait_sent(5, 1000);
        check("rr_b0", sent_at(0), 8'h10);
        check("rr_b1", sent_at(1), 8'h11);
        check("rr_b2", sent_at(2), 8'h12);
        check("rr_b3", sent_at(3), 8'h13);
        check("rr_b4", sent_at(4), 8'h10);
        check("rr_id1", ready_at(1), 1);
        check("rr_id4", ready_at(4), 0);

        // Packet lock on requester 1
        do_reset();
        src_q[1].push_back({1'b0, 8'h01});
        src_q[1].push_back({1'b0, 8'h02});
        src_q[1].push_back({1'b1, 8'h03});
        for (int t = 0; t < 50 && ready_log.size() == 0; t++) @(negedge sys_clk);
        check("pkt_locked", locked, 1'b1);
        check("pkt_grant", grant_id, 2'd1);
        src_q[0].push_back({1'b1, 8'hA0});
        src_q[3].push_back({1'b1, 8'hD3});
        wait_sent(5, 1000);
        check("pkt_b0", sent_at(0), 8'h01);
        check("pkt_b1", sent_at(1), 8'h02);
        check("pkt_b2", sent_at(2), 8'h03);
        check("pkt_b3", sent_at(3), 8'hD3);
        check("pkt_b4", sent_at(4), 8'hA0);
        check("pkt_unlock", locked, 1'b0);

        // Launch timeout with busy tied low
        do_reset();
        busy_tie = 1'b1;
        err0 = err_cnt;
        src_q[0].push_back({1'b0, 8'h77});
        src_q[0].push_back({1'b0, 8'h77});
        for (int t = 0; t < 50 && uart_en !== 1'b1; t++) @(negedge sys_clk);
        hi = 0;
        while (uart_en === 1'b1 && hi < 100) begin
            hi++;
            @(negedge sys_clk);
        end
        check("to_err_pulse", err_timeout, 1'b1);
        check("to_locked_clr", locked, 1'b0);
        lo = 0;
        while (uart_en === 1'b0 && lo < 100) begin
            lo++;
            @(negedge sys_clk);
        end
        check("to_en_high_cycles", hi, WAIT_MAX);
        check("to_gap_cycles", lo, 2);
        check("to_err_count", err_cnt - err0, 1);

        // Busy already high in IDLE
        do_reset();
        force_busy = 1'b1;
        src_q[1].push_back({1'b1, 8'h3C});
        repeat (10) @(negedge sys_clk);
        check("busy_no_ready", ready_log.size(), 0);
        check("busy_no_en", uart_en, 1'b0);
        force_busy = 1'b0;
        n = 0;
        while (n < 50) begin
            @(negedge sys_clk);
            n++;
            if (req_ready != 4'b0) break;
        end
        check("busy_launch_lat", n, 1);
        check("busy_ready_vec", req_ready, 4'b0010);
        wait_sent(1, 400);
        check("busy_byte", sent_at(0), 8'h3C);

        // Reset in the middle of a frame
        do_reset();
        src_q[2].push_back({1'b0, 8'h5A});
        for (int t = 0; t < 50 && !m_busy; t++) @(negedge sys_clk);
        repeat (5 * BIT_CYC + 3) @(negedge sys_clk);
        check("mid_pre_grant", grant_id, 2'd2);
        check("mid_pre_locked", locked, 1'b1);
        #2;
        sys_rst_n = 1'b0;
        #1;
        check("mid_en", uart_en, 1'b0);
        check("mid_ready", req_ready, 4'b0);
        check("mid_grant", grant_id, 2'd0);
        check("mid_locked", locked, 1'b0);
        src_q[3].push_back({1'b1, 8'h33});
        src_q[1].push_back({1'b1, 8'h11});
        @(negedge sys_clk);
        @(negedge sys_clk);
        sent_q.delete();
        ready_log.delete();
        sys_rst_n = 1'b1;
        wait_sent(2, 1000);
        check("mid_first_id", ready_at(0), 1);
        check("mid_b0", sent_at(0), 8'h11);
        check("mid_b1", sent_at(1), 8'h33);

        check("ready_pulse_shape", viol, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
